// File: rtl/mem_stall_responder_if.sv
// Request/response bundle between a pipeline requester and mem_stall_responder.
interface mem_stall_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  modport master (
    output addr, data_in, rd, wr,
    input  data_out, done, stall, err
  );

  modport slave (
    input  addr, data_in, rd, wr,
    output data_out, done, stall, err
  );
endinterface

// File: rtl/mem_stall_responder.sv
// Word-organised memory with configurable access latency and a stall/done
// handshake; invalid requests are rejected with a one-cycle err pulse.
module mem_stall_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stall_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] HI_MASK = 16'hFFFF << (ADDR_W + 1);

  state_t              state;
  logic [3:0]          cnt;
  logic                op_wr;
  logic [ADDR_W-1:0]   idx;
  logic [15:0]         wdata;
  logic [15:0]         mem [2**ADDR_W];

  logic                req;
  logic                valid;
  logic                accept;
  logic                fin;
  logic                fin_wr;
  logic [ADDR_W-1:0]   fin_idx;
  logic [15:0]         fin_data;
  logic [15:0]         rd_word;

  always_comb begin
    req       = bus.rd | bus.wr;
    valid     = (bus.rd ^ bus.wr) && !bus.addr[0] && ((bus.addr & HI_MASK) == '0);
    accept    = (state != BUSY) && valid;
    bus.stall = (state == BUSY) || accept;
    // With LATENCY==1 the acceptance edge is also the completion edge, so the
    // access is taken straight from the bus instead of the latched copy.
    if (LATENCY == 1) begin
      fin_wr   = bus.wr;
      fin_idx  = bus.addr[ADDR_W:1];
      fin_data = bus.data_in;
      fin      = accept && !rst;
    end else begin
      fin_wr   = op_wr;
      fin_idx  = idx;
      fin_data = wdata;
      fin      = (state == BUSY) && (cnt == 4'd1) && !rst;
    end
  end

  assign rd_word = mem[fin_idx];

  // Storage is never reset; writes land only on the completion edge.
  always_ff @(posedge clk) begin
    if (fin && fin_wr) begin
      mem[fin_idx] <= fin_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.data_out <= '0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      if (fin) begin
        bus.done     <= 1'b1;
        bus.data_out <= fin_wr ? fin_data : rd_word;
      end
      case (state)
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
          end
        end
        default: begin
          if (valid) begin
            op_wr <= bus.wr;
            idx   <= bus.addr[ADDR_W:1];
            wdata <= bus.data_in;
            cnt   <= 4'(LATENCY - 1);
            state <= (LATENCY == 1) ? DONE : BUSY;
          end else begin
            state <= IDLE;
            if (req) begin
              bus.err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
